// File: rtl/reset_sequencer.sv
// Staged per-peripheral reset release: each stage is released after a settle
// delay, then the sequencer waits for that stage's ready before moving on.
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16,
  parameter int TIMEOUT     = 1024,
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk_sys,
  input  logic                  reset_sys,
  input  logic                  locked,
  input  logic                  restart,
  input  logic [NUM_STAGES-1:0] ready_in,
  output logic [NUM_STAGES-1:0] reset_out,
  output logic                  done,
  output logic                  fault,
  output logic [SW-1:0]         fault_stage
);

  localparam int CNT_MAX = (STAGE_DELAY > TIMEOUT) ? STAGE_DELAY : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] DELAY_LAST   = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [SW-1:0] LAST_STAGE   = SW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_DELAY,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           k_q, k_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   reset_out_q, reset_out_d;
  logic                    done_q, done_d;
  logic                    fault_q, fault_d;
  logic [SW-1:0]           fault_stage_q, fault_stage_d;

  // locked is asynchronous to clk_sys; the synchronizer is deliberately not reset
  logic locked_meta_q, locked_s_q;

  always_ff @(posedge clk_sys) begin
    locked_meta_q <= locked;
    locked_s_q    <= locked_meta_q;
  end

  logic [NUM_STAGES-1:0] stage_sel;
  logic                  ready_k;

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage_sel
    assign stage_sel[gi] = (k_q == SW'(gi));
  end

  assign ready_k = |(ready_in & stage_sel);

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    cnt_d         = cnt_q;
    reset_out_d   = reset_out_q;
    done_d        = done_q;
    fault_d       = fault_q;
    fault_stage_d = fault_stage_q;

    if (!locked_s_q || restart) begin
      state_d       = S_HOLD;
      k_d           = '0;
      cnt_d         = '0;
      reset_out_d   = '1;
      done_d        = 1'b0;
      fault_d       = 1'b0;
      fault_stage_d = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          state_d = S_DELAY;
          k_d     = '0;
          cnt_d   = '0;
        end
        S_DELAY: begin
          if (cnt_q == DELAY_LAST) begin
            reset_out_d = reset_out_q & ~stage_sel;
            cnt_d       = '0;
            state_d     = S_WAIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WAIT: begin
          // a ready seen on the final allowed edge still wins over the timeout
          if (ready_k) begin
            if (k_q == LAST_STAGE) begin
              done_d      = 1'b1;
              reset_out_d = '0;
              state_d     = S_DONE;
            end else begin
              k_d     = k_q + SW'(1);
              cnt_d   = '0;
              state_d = S_DELAY;
            end
          end else if (cnt_q == TIMEOUT_LAST) begin
            fault_d       = 1'b1;
            fault_stage_d = k_q;
            reset_out_d   = reset_out_q | stage_sel;
            state_d       = S_FAULT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          reset_out_d = '0;
          done_d      = 1'b1;
        end
        S_FAULT: begin
          done_d = 1'b0;
        end
        default: begin
          state_d = S_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset_sys) begin
      state_q       <= S_HOLD;
      k_q           <= '0;
      cnt_q         <= '0;
      reset_out_q   <= '1;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      cnt_q         <= cnt_d;
      reset_out_q   <= reset_out_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
    end
  end

  assign reset_out   = reset_out_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign fault_stage = fault_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: expected outputs come from a timeline model that
// computes release/accept/fault edges arithmetically from stage latencies.
module tb_reset_sequencer;

  localparam int NS = 4;
  localparam int SD = 16;
  localparam int TO = 1024;
  localparam int SW = 2;
  localparam int VW = NS + 2 + SW;

  logic          clk_sys   = 1'b0;
  logic          reset_sys = 1'b1;
  logic          locked    = 1'b1;
  logic          restart   = 1'b0;
  logic [NS-1:0] ready_in  = '0;
  logic [NS-1:0] reset_out;
  logic          done;
  logic          fault;
  logic [SW-1:0] fault_stage;

  always #5 clk_sys = ~clk_sys;

  reset_sequencer #(
    .NUM_STAGES (NS),
    .STAGE_DELAY(SD),
    .TIMEOUT    (TO)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_sys  (reset_sys),
    .locked     (locked),
    .restart    (restart),
    .ready_in   (ready_in),
    .reset_out  (reset_out),
    .done       (done),
    .fault      (fault),
    .fault_stage(fault_stage)
  );

  localparam logic [VW-1:0] RST_V = {{NS{1'b1}}, 1'b0, 1'b0, {SW{1'b0}}};

  int n_cmp  = 0;
  int n_fail = 0;

  // Timeline model: edge t=0 is E0; lat_a[k] is the edge offset after release
  // at which ready_in[k] is first presented (> TO means never).
  int lat_a[NS];
  int rel_t[NS];
  int acc_t[NS];
  int tfault;
  int fstage;
  int done_t;
  int fill_mode;
  logic [VW-1:0] obs;
  logic [VW-1:0] exp_v;

  function automatic void plan();
    int  t    = SD;
    bit  stop = 1'b0;
    tfault = -1;
    fstage = 0;
    done_t = -1;
    for (int k = 0; k < NS; k++) begin
      rel_t[k] = -1;
      acc_t[k] = -1;
    end
    for (int k = 0; k < NS; k++) begin
      if (!stop) begin
        rel_t[k] = t;
        if (lat_a[k] <= TO) begin
          acc_t[k] = t + lat_a[k];
          t        = acc_t[k] + SD;
        end else begin
          tfault = t + TO;
          fstage = k;
          stop   = 1'b1;
        end
      end
    end
    if (tfault < 0) done_t = acc_t[NS-1];
  endfunction

  function automatic logic fill_bit();
    if (fill_mode == 0) return 1'b0;
    if (fill_mode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // Outside a stage's wait window its ready is don't-care, so it gets filler.
  function automatic logic ready_for(int k, int t);
    if (rel_t[k] < 0 || t <= rel_t[k]) return fill_bit();
    if (acc_t[k] < 0 || t < acc_t[k]) return 1'b0;
    if (t == acc_t[k]) return 1'b1;
    return fill_bit();
  endfunction

  function automatic logic [VW-1:0] exp_at(int t);
    logic [NS-1:0] ro = '1;
    logic          d;
    logic          f;
    logic [SW-1:0] fs;
    for (int k = 0; k < NS; k++)
      if (rel_t[k] >= 0 && t >= rel_t[k]) ro[k] = 1'b0;
    f = (tfault >= 0 && t >= tfault);
    if (f) ro[fstage] = 1'b1;
    d  = (done_t >= 0 && t >= done_t);
    fs = f ? SW'(fstage) : '0;
    return {ro, d, f, fs};
  endfunction

  task automatic drive_edge(input int t);
    @(negedge clk_sys);
    for (int k = 0; k < NS; k++) ready_in[k] = ready_for(k, t);
    @(posedge clk_sys);
    #1;
    obs   = {reset_out, done, fault, fault_stage};
    exp_v = exp_at(t);
  endtask

  task automatic tick(input logic [NS-1:0] rdy);
    @(negedge clk_sys);
    ready_in = rdy;
    @(posedge clk_sys);
    #1;
    obs = {reset_out, done, fault, fault_stage};
  endtask

  task automatic go_hold();
    reset_sys = 1'b1;
    locked    = 1'b1;
    restart   = 1'b0;
    repeat (3) tick(NS'($urandom));
    reset_sys = 1'b0;
  endtask

  function automatic int end_time();
    return (done_t >= 0) ? done_t : tfault;
  endfunction

  task automatic test_reset();
    reset_sys = 1'b1;
    locked    = 1'b1;
    restart   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(NS'($urandom));
      if (i >= 1) begin
        n_cmp++;
        if (obs !== RST_V) begin
          n_fail++;
          $display("FAIL reset_hold i=%0d got=%b want=%b", i, obs, RST_V);
        end
      end
    end
    reset_sys = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_nominal();
    for (int k = 0; k < NS; k++) lat_a[k] = 3;
    fill_mode = 0;
    plan();
    for (int t = 0; t <= end_time() + 10; t++) begin
      drive_edge(t);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL nominal t=%0d got=%b want=%b", t, obs, exp_v);
      end
    end
    $display("test_nominal: rel0=%0d done_t=%0d", rel_t[0], done_t);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      go_hold();
      for (int k = 0; k < NS; k++) begin
        int r = int'($urandom_range(0, 9));
        if (r == 0)      lat_a[k] = TO + 1;
        else if (r == 1) lat_a[k] = TO - int'($urandom_range(0, 1));
        else             lat_a[k] = int'($urandom_range(1, 40));
      end
      fill_mode = 2;
      plan();
      for (int t = 0; t <= end_time() + 20; t++) begin
        drive_edge(t);
        n_cmp++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL random%0d t=%0d got=%b want=%b", it, t, obs, exp_v);
        end
      end
      $display("test_random %0d: lat=%0d,%0d,%0d,%0d done_t=%0d fault_t=%0d",
               it, lat_a[0], lat_a[1], lat_a[2], lat_a[3], done_t, tfault);
    end
  endtask

  task automatic test_timeout();
    logic [VW-1:0] want_fault;
    want_fault = {4'b1100, 1'b0, 1'b1, 2'd2};
    go_hold();
    lat_a[0] = 3; lat_a[1] = 3; lat_a[2] = TO + 1; lat_a[3] = 3;
    fill_mode = 0;
    plan();
    for (int t = 0; t <= tfault + 100; t++) begin
      drive_edge(t);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL timeout t=%0d got=%b want=%b", t, obs, exp_v);
      end
      if (t == rel_t[2] + TO) begin
        n_cmp++;
        if (obs !== want_fault) begin
          n_fail++;
          $display("FAIL timeout_edge t=%0d got=%b want=%b", t, obs, want_fault);
        end
      end
    end
    $display("test_timeout: rel2=%0d fault_t=%0d", rel_t[2], tfault);
  endtask

  task automatic test_restart_after_fault();
    restart = 1'b1;
    tick('1);
    restart = 1'b0;
    n_cmp++;
    if (obs !== RST_V) begin
      n_fail++;
      $display("FAIL restart_clear got=%b want=%b", obs, RST_V);
    end
    for (int k = 0; k < NS; k++) lat_a[k] = 1;
    fill_mode = 1;
    plan();
    for (int t = 0; t <= end_time() + 5; t++) begin
      drive_edge(t);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL restart_seq t=%0d got=%b want=%b", t, obs, exp_v);
      end
      if (t == 4 * (SD + 1) - 1 || t == 4 * (SD + 1)) begin
        n_cmp++;
        if (done !== (t == 4 * (SD + 1))) begin
          n_fail++;
          $display("FAIL restart_done t=%0d got=%b want=%b", t, done, (t == 4 * (SD + 1)));
        end
      end
    end
    $display("test_restart_after_fault: done_t=%0d", done_t);
  endtask

  task automatic test_timeout_boundary();
    go_hold();
    lat_a[0] = 2; lat_a[1] = TO; lat_a[2] = 2; lat_a[3] = 2;
    fill_mode = 0;
    plan();
    for (int t = 0; t <= end_time() + 10; t++) begin
      drive_edge(t);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL boundary t=%0d got=%b want=%b", t, obs, exp_v);
      end
    end
    $display("test_timeout_boundary: acc1=%0d rel2=%0d", acc_t[1], rel_t[2]);
  endtask

  task automatic test_lock_loss();
    int t0;
    go_hold();
    lat_a[0] = 3; lat_a[1] = 60; lat_a[2] = 3; lat_a[3] = 3;
    fill_mode = 2;
    plan();
    t0 = rel_t[1] + 5;
    for (int t = 0; t <= t0; t++) begin
      drive_edge(t);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL lockloss_pre t=%0d got=%b want=%b", t, obs, exp_v);
      end
    end
    locked = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      if (i == 6) locked = 1'b1;
      if (i <= 2) drive_edge(t0 + i);
      else begin
        tick(NS'($urandom));
        exp_v = RST_V;
      end
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL lockloss_edge%0d got=%b want=%b", i, obs, exp_v);
      end
    end
    for (int k = 0; k < NS; k++) lat_a[k] = 3;
    plan();
    for (int t = 0; t <= end_time() + 5; t++) begin
      drive_edge(t);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL lockloss_reseq t=%0d got=%b want=%b", t, obs, exp_v);
      end
    end
    $display("test_lock_loss: resequence done_t=%0d", done_t);
  endtask

  task automatic test_reset_mid();
    go_hold();
    lat_a[0] = 4; lat_a[1] = 6; lat_a[2] = 3; lat_a[3] = 3;
    fill_mode = 2;
    plan();
    for (int t = 0; t <= acc_t[1] + 5; t++) begin
      drive_edge(t);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL resetmid_pre t=%0d got=%b want=%b", t, obs, exp_v);
      end
    end
    reset_sys = 1'b1;
    tick(NS'($urandom));
    reset_sys = 1'b0;
    n_cmp++;
    if (obs !== RST_V) begin
      n_fail++;
      $display("FAIL resetmid_apply got=%b want=%b", obs, RST_V);
    end
    for (int k = 0; k < NS; k++) lat_a[k] = int'($urandom_range(1, 20));
    plan();
    for (int t = 0; t <= end_time() + 5; t++) begin
      drive_edge(t);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL resetmid_reseq t=%0d got=%b want=%b", t, obs, exp_v);
      end
    end
    $display("test_reset_mid: resequence done_t=%0d", done_t);
  endtask

  task automatic test_back_to_back();
    go_hold();
    for (int k = 0; k < NS; k++) lat_a[k] = int'($urandom_range(1, 10));
    fill_mode = 2;
    plan();
    for (int t = 0; t <= end_time() + 3; t++) begin
      drive_edge(t);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_first t=%0d got=%b want=%b", t, obs, exp_v);
      end
    end
    restart = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(NS'($urandom));
      n_cmp++;
      if (obs !== RST_V) begin
        n_fail++;
        $display("FAIL b2b_restart i=%0d got=%b want=%b", i, obs, RST_V);
      end
    end
    restart = 1'b0;
    for (int k = 0; k < NS; k++) lat_a[k] = int'($urandom_range(1, 10));
    plan();
    for (int t = 0; t <= end_time() + 3; t++) begin
      drive_edge(t);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_second t=%0d got=%b want=%b", t, obs, exp_v);
      end
    end
    $display("test_back_to_back: second done_t=%0d", done_t);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_random();
    test_timeout();
    test_restart_after_fault();
    test_timeout_boundary();
    test_lock_loss();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Sits in the `clk_sys` domain and consumes the system controller's `reset_sys` and `locked`. It produces a staged, per-peripheral reset bus for the SoC. Each stage's reset is released in order after a programmable settle delay. The sequencer then waits for that peripheral's ready handshake before moving to the next stage. A fault is flagged if the handshake times out, and all stages are re-asserted whenever the clock loses lock or software requests a restart.

## Interface
- `NUM_STAGES`, 4: number of sequenced reset outputs; legal range 1..16.
- `STAGE_DELAY`, 16: `clk_sys` cycles between stage entry and that stage's reset release; must be ≥1.
- `TIMEOUT`, 1024: cycles allowed for `ready_in[k]` after release; must be ≥1.
- Derived: `SW = max(1, $clog2(NUM_STAGES))`; counter width `$clog2(max(STAGE_DELAY, TIMEOUT))+1`.
- `clk_sys`  in  1  system clock.
- `reset_sys`  in  1  synchronous, active-high reset.
- `locked`  in  1  MMCM lock from clock wizard; asynchronous to `clk_sys`.
- `restart`  in  1  level/pulse, `clk_sys` domain; requests a full re-sequence.
- `ready_in`  in  `NUM_STAGES`  per-stage ready acknowledge, `clk_sys` domain, no internal sync.
- `reset_out`  out  `NUM_STAGES`  per-stage active-high reset, registered.
- `done`  out  1  all stages released and acknowledged.
- `fault`  out  1  sticky handshake timeout flag.
- `fault_stage`  out  `SW`  index of the stage that timed out.

## Operation
- `locked` passes through a 2-flop synchronizer (`locked_s`). The synchronizer flops are not reset.
- Priority each edge: `reset_sys` > (`locked_s`==0 or `restart`==1) > FSM.
- Reset values: `reset_out`=all 1s, `done`=0, `fault`=0, `fault_stage`=0, state HOLD, stage index k=0, counter=0.
- Abort: `locked_s` low or `restart` high in any state forces the same values as reset.
- HOLD: all resets asserted. Go to DELAY (k=0, cnt=0) when `locked_s`=1 and `restart`=0.
- DELAY: cnt increments each edge.
  - At the edge where cnt==STAGE_DELAY-1: clear `reset_out[k]`, cnt=0, go to WAIT.
- WAIT: `ready_in[k]` sampled each edge.
  - If high, go to NEXT behaviour on that edge:
    - if k<NUM_STAGES-1: k++, cnt=0, DELAY.
    - else: `done`=1, DONE.
  - If low and cnt==TIMEOUT-1: `fault`=1, `fault_stage`=k, re-assert `reset_out[k]`, go to FAULT.
  - Otherwise cnt++.
  - Ready has priority over timeout on the same edge.
- DONE: `reset_out`=0, `done`=1. Held until abort or `reset_sys`.
- FAULT: stages 0..k-1 stay released, stages k..NUM_STAGES-1 asserted, `done`=0. Held until abort or `reset_sys`. Abort clears `fault`.
- `ready_in[j]` for j≠k is ignored. A ready that is already high is accepted on the first WAIT edge.
- Stages released earlier are never re-asserted except by abort or `reset_sys`.

## Timing
- E0 is the first edge with `reset_sys` sampled low, with `locked` stable high for ≥2 prior cycles. E0 performs HOLD→DELAY.
- `reset_out[0]` falls after edge E0+STAGE_DELAY.
- Erel(k) is the edge releasing stage k. Ready is accepted at edges Erel+1..Erel+TIMEOUT.
  - If ready is accepted at edge Er, then `reset_out[k+1]` falls at Er+STAGE_DELAY.
  - If ready is accepted at edge Er on the last stage, `done` rises at Er.
- If ready is not seen, `fault` rises at Erel+TIMEOUT.
- `locked` falling reaches `reset_out`=all 1s within 3 edges: 2 synchronizer edges + 1.
- `restart` high takes effect at the next edge. `reset_sys` takes effect at the next edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Nominal sequence.** Defaults; each `ready_in[k]` rises 3 cycles after `reset_out[k]` falls.
  - `reset_out[0]` falls at E0+16.
  - Each later stage falls 3+16 edges after the previous one.
  - `done`=1 at the edge that samples `ready_in[3]`; `fault` stays 0.
- **Timeout.** `ready_in[2]` held 0.
  - `fault`=1 and `fault_stage`=2 at Erel(2)+1024.
  - `reset_out`=4'b1100, `done`=0, and outputs stay stable for 100 further cycles.
- **Timeout boundary.** `ready_in[1]` rises exactly at Erel(1)+1024.
  - The handshake is accepted; `fault` stays 0.
  - `reset_out[2]` falls at Erel(1)+1024+16.
- **Lock loss mid-sequence.** Drop `locked` for 5 cycles while in WAIT for stage 1.
  - `reset_out`=4'hF within 3 edges.
  - After `locked` returns, the sequence restarts from stage 0 with nominal timing.
- **Restart after fault.** Run the timeout scenario, then pulse `restart` for 1 cycle with all `ready_in` held 1.
  - `fault` clears at the next edge.
  - Full resequence completes; `done`=1 after 4×(16+1) edges.
- **Reset mid-sequence.** Assert `reset_sys` during DELAY of stage 2.
  - All outputs return to reset values at the next edge.
  - After release, nominal sequence timing restarts from E0.
